// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM constants, FSM encoding and duty saturation helper
package pwm_pkg;

  localparam int          PWM_CNT_W   = 16;
  localparam logic [15:0] PWM_TIMEOUT = 16'd50000;
  localparam int          DUTY_W      = 10;
  localparam int          DIV_CYCLES  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } pwm_state_t;

  // Quotients of 1024 or more (bit 10 set, or overflow detected at start) clamp to full scale
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DIV_CYCLES-1:0] q,
                                                 input logic                  ovf);
    return (ovf || q[DIV_CYCLES-1]) ? {DUTY_W{1'b1}} : q[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_div.sv
// rtl/pwm_div.sv - sequential restoring divider producing an NQ-bit quotient in NQ cycles
module pwm_div import pwm_pkg::*; #(
  parameter int DW = PWM_CNT_W + DUTY_W,
  parameter int VW = PWM_CNT_W,
  parameter int NQ = DIV_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NQ-1:0] quotient,
  output logic          ovf
);

  localparam int CW = $clog2(NQ + 1);

  logic [VW-1:0] rem;
  logic [VW-1:0] div_r;
  logic [NQ-1:0] bits;
  logic [NQ-1:0] q;
  logic [CW-1:0] cnt;
  logic          ovf_r;

  logic          accept;
  logic [DW-1:0] hi_part;
  logic          ovf_now;
  logic [VW-1:0] cur_rem;
  logic [VW-1:0] cur_div;
  logic          cur_bit;
  logic [VW:0]   trial;
  logic          ge;
  logic [VW-1:0] next_rem;

  // One restoring step; on the accept cycle it works straight from the inputs so the
  // first quotient bit is produced in the same cycle the operands are captured
  always_comb begin
    accept   = start && !busy && !abort;
    hi_part  = dividend >> NQ;
    ovf_now  = hi_part >= {{(DW-VW){1'b0}}, divisor};
    cur_rem  = accept ? hi_part[VW-1:0] : rem;
    cur_bit  = accept ? dividend[NQ-1]  : bits[NQ-1];
    cur_div  = accept ? divisor         : div_r;
    trial    = {cur_rem, cur_bit};
    ge       = trial >= {1'b0, cur_div};
    next_rem = ge ? (trial[VW-1:0] - cur_div) : trial[VW-1:0];
  end

  // Iteration control: load, shift NQ quotient bits, then strobe done for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      rem   <= '0;
      div_r <= '0;
      bits  <= '0;
      q     <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (accept) begin
        busy  <= 1'b1;
        div_r <= divisor;
        rem   <= next_rem;
        bits  <= {dividend[NQ-2:0], 1'b0};
        q     <= {{(NQ-1){1'b0}}, ge};
        cnt   <= CW'(NQ - 1);
        ovf_r <= ovf_now;
      end else if (busy) begin
        rem  <= next_rem;
        bits <= {bits[NQ-2:0], 1'b0};
        q    <= {q[NQ-2:0], ge};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = q;
  assign ovf      = ovf_r;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time/duty measurement with stuck-input detection
module pwm_capture import pwm_pkg::*; #(
  parameter int          CNT_W   = PWM_CNT_W,
  parameter logic [15:0] TIMEOUT = PWM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              stuck
);

  localparam int DW = CNT_W + DUTY_W;

  logic s1, s2, s3;
  logic rise, fall, edge_det;

  pwm_state_t       state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] high_lat;
  logic [CNT_W-1:0] pend_per;
  logic [CNT_W-1:0] pend_high;
  logic [15:0]      idle_cnt;

  logic                  timeout;
  logic                  div_start;
  logic                  div_abort;
  logic                  div_busy;
  logic                  div_done;
  logic                  div_ovf;
  logic [DIV_CYCLES-1:0] div_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer plus a delay flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Edge, timeout and divider handshake decode; an edge always beats a timeout
  always_comb begin
    rise      = s2 & ~s3;
    fall      = ~s2 & s3;
    edge_det  = rise | fall;
    timeout   = en && (state != IDLE) && !edge_det && !stuck &&
                (idle_cnt == TIMEOUT - 16'd1);
    div_start = en && (state == LOW) && rise && !div_busy;
    div_abort = !en || timeout;
  end

  pwm_div #(
    .DW (DW),
    .VW (CNT_W),
    .NQ (DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend ({high_lat, {DUTY_W{1'b0}}}),
    .divisor  (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .ovf      (div_ovf)
  );

  // Measurement FSM, counters and registered outputs; outputs hold while disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      high_cnt  <= '0;
      high_lat  <= '0;
      pend_per  <= '0;
      pend_high <= '0;
      idle_cnt  <= '0;
      duty      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        idle_cnt <= '0;
      end else begin
        per_cnt  <= rise ? CNT_W'(1) : sat_inc(per_cnt);
        high_cnt <= rise ? CNT_W'(1) : sat_inc(high_cnt);

        if (edge_det || state == IDLE || timeout)
          idle_cnt <= '0;
        else if (idle_cnt != 16'hFFFF)
          idle_cnt <= idle_cnt + 16'd1;

        if (rise)
          stuck <= 1'b0;

        if (div_done) begin
          duty      <= sat_duty(div_q, div_ovf);
          period    <= pend_per;
          high_time <= pend_high;
          valid     <= 1'b1;
        end

        if (div_start) begin
          pend_per  <= per_cnt;
          pend_high <= high_lat;
        end

        case (state)
          IDLE: state <= ARM;
          ARM:  if (rise) state <= HIGH;
          HIGH: if (fall) begin
                  state    <= LOW;
                  high_lat <= high_cnt;
                end
          LOW:  if (rise) state <= HIGH;
          default: state <= IDLE;
        endcase

        if (timeout) begin
          state     <= ARM;
          stuck     <= 1'b1;
          duty      <= s2 ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
          period    <= '0;
          high_time <= '0;
          valid     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm_in;
  logic [9:0]  duty;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        stuck;

  pwm_capture dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int period;
    int high;
    int stuck;
    int rise_cyc;
    bit lat_chk;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  bit   have_pend = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected measurement
  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got duty=%0d period=%0d high=%0d, required no valid (cycle %0d)",
                 duty, period, high_time, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("valid_duty", int'(duty), e.duty);
        check("valid_period", int'(period), e.period);
        check("valid_high", int'(high_time), e.high);
        check("valid_stuck", int'(stuck), e.stuck);
        if (e.lat_chk) check("valid_latency", cyc - e.rise_cyc, 14);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_next(input int d, input int p, input int h);
    pend.duty     = d;
    pend.period   = p;
    pend.high     = h;
    pend.stuck    = 0;
    pend.rise_cyc = 0;
    pend.lat_chk  = 1'b1;
    have_pend     = 1'b1;
  endtask

  task automatic rise_pin();
    pwm_in = 1'b1;
    if (have_pend) begin
      pend.rise_cyc = cyc;
      sb.push_back(pend);
      have_pend = 1'b0;
    end
  endtask

  task automatic pulse(input int h, input int l);
    rise_pin();
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic check_outputs(input string tag, input int d, input int p, input int h, input int s);
    check({tag, "_duty"}, int'(duty), d);
    check({tag, "_period"}, int'(period), p);
    check({tag, "_high"}, int'(high_time), h);
    check({tag, "_stuck"}, int'(stuck), s);
  endtask

  initial begin
    exp_t st;
    rst    = 1'b0;
    en     = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    check_outputs("reset", 0, 0, 0, 0);
    check("reset_valid", int'(valid), 0);
    rst = 1'b1;
    tick(5);
    check("idle_valid", int'(valid), 0);

    // 25 kHz at 50 %, then 500/4000 and 3999/4000
    en = 1'b1;
    tick(2);
    pulse(2000, 2000);
    expect_next(512, 4000, 2000);
    pulse(500, 3500);
    expect_next(128, 4000, 500);
    pulse(3999, 1);
    expect_next(1023, 4000, 3999);
    rise_pin();

    // Held high: one stuck report, then stuck clears on the next rise
    st.duty = 1023; st.period = 0; st.high = 0; st.stuck = 1;
    st.rise_cyc = 0; st.lat_chk = 1'b0;
    sb.push_back(st);
    tick(50030);
    check_outputs("stuck_hold", 1023, 0, 0, 1);
    pwm_in = 1'b0;
    tick(2000);
    check("stuck_low", int'(stuck), 1);
    rise_pin();
    tick(10);
    check("stuck_clear", int'(stuck), 0);
    tick(990);
    pwm_in = 1'b0;
    tick(3000);
    expect_next(256, 4000, 1000);
    pulse(30, 70);

    // Reset while the divider is working on the 30/100 period
    rise_pin();
    tick(6);
    rst = 1'b0;
    #1;
    check_outputs("mid_div_reset", 0, 0, 0, 0);
    check("mid_div_reset_valid", int'(valid), 0);
    pwm_in = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(30);
    pulse(30, 70);
    expect_next(307, 100, 30);
    pulse(30, 70);

    // 10-cycle period: every other measurement lands while the divider is busy
    for (int i = 1; i <= 10; i++) begin
      if (i == 1) expect_next(307, 100, 30);
      else if (i % 2 == 1) expect_next(409, 10, 4);
      pulse(4, 6);
    end
    expect_next(409, 10, 4);
    pulse(50, 150);

    // Disable mid-period: outputs frozen, partial period after re-enable discarded
    expect_next(256, 200, 50);
    rise_pin();
    tick(50);
    pwm_in = 1'b0;
    tick(20);
    en = 1'b0;
    tick(130);
    pulse(50, 150);
    pulse(50, 150);
    check_outputs("disabled", 256, 200, 50, 0);
    en = 1'b1;
    tick(20);
    pulse(100, 100);
    expect_next(512, 200, 100);
    pulse(100, 100);

    // Disable while a division is running: aborted, no valid
    rise_pin();
    tick(6);
    en = 1'b0;
    tick(30);
    check_outputs("abort", 512, 200, 100, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
